ntt_result_collector: RTL and testbench
=======================================

# ntt_result_collector

Output-side consumer for the FULL_NTT_iNTT pipeline. It accepts the 8-lane, 12-bit coefficient beats the pipeline emits on `valid_out`/`coeffs_out`, assembles every 32 beats into one 256-coefficient polynomial in a ping-pong buffer, and streams each finished polynomial out one coefficient per cycle over a valid/ready handshake in natural index order. It sits between the transform core and the downstream polynomial memory or arithmetic unit, and absorbs the mismatch between the core's push-only output and a back-pressured consumer.

## Interface
- LANES, 8, coefficients per input beat
- W, 12, coefficient width
- N, 256, coefficients per polynomial
- Q, 3329, modulus used for the range check
- clk  in  1  clock; all state updates on the rising edge
- r  in  1  reset; one clock; reset is asynchronous and active-low
- valid_in  in  1  input beat strobe, driven from the core's valid_out; no back-pressure toward the core
- coeffs_in  in  LANES x W (unpacked array [LANES-1:0])  input beat; lane k carries index beat*LANES+k
- out_valid  out  1  coeff_out holds a valid coefficient
- out_ready  in  1  downstream accepts coeff_out this cycle
- coeff_out  out  W  current coefficient
- out_idx  out  log2(N)  index of coeff_out within its polynomial
- out_last  out  1  high with out_idx == N-1
- clr_err  in  1  synchronous clear of the sticky flags
- overflow  out  1  sticky: at least one polynomial was dropped
- range_err  out  1  sticky: an accepted coefficient was >= Q

## Operation
- Two banks, B0/B1, each holding N x W. Per-bank state: EMPTY, FILLING, FULL, DRAINING.
- Write FSM:
  - States WR_IDLE, WR_FILL, WR_DROP; beat counter wr_beat is 0..N/LANES-1 (0..31); wr_bank pointer.
  - WR_IDLE + valid_in: if bank[wr_bank] is EMPTY, or it is DRAINING and completes its final handshake this same cycle, store the beat at beat 0, set the bank to FILLING, and go to WR_FILL. Otherwise go to WR_DROP, set overflow, and discard the beat.
  - WR_FILL + valid_in: store the beat at wr_beat. On beat 31, set the bank to FULL, toggle wr_bank, and return to WR_IDLE.
  - WR_DROP: count valid_in beats without storing them. After beat 31, return to WR_IDLE. wr_bank does not toggle.
  - Cycles without valid_in never advance wr_beat. Gaps between beats are legal.
- Read FSM:
  - States RD_IDLE, RD_STREAM; counter rd_idx 0..N-1; rd_bank pointer.
  - RD_IDLE: when bank[rd_bank] is FULL, set it to DRAINING, set rd_idx to 0, and go to RD_STREAM.
  - RD_STREAM: out_valid=1, coeff_out=bank[rd_bank][rd_idx], out_idx=rd_idx.
  - Each out_valid&&out_ready increments rd_idx.
  - On the handshake at rd_idx==N-1: the bank becomes EMPTY, rd_bank toggles, and the FSM returns to RD_IDLE.
  - Outputs hold stable while out_valid && !out_ready.
- range_err is set if any lane of an accepted (stored) beat is >= Q. The data is stored unchanged. Dropped beats are not checked.
- clr_err clears overflow and range_err. A set event in the same cycle wins, so the flag stays 1.

## Timing
- Reset values: out_valid=0, coeff_out=0, out_idx=0, out_last=0, overflow=0, range_err=0. Internal reset values: both banks EMPTY, wr_bank=rd_bank=0, wr_beat=0, rd_idx=0, write FSM in WR_IDLE, read FSM in RD_IDLE. Bank storage is not reset.
- Reset asserted mid-polynomial discards the partial fill and any undrained data. out_valid falls asynchronously.
- Latency: the last beat of a polynomial stored at edge t gives bank FULL after t. out_valid rises after edge t+1, i.e. 2 cycles from last beat to first output.
- Back-to-back polynomial streaming: out_valid may fall for exactly 1 cycle (RD_IDLE) between polynomials.
- Throughput: input is up to 1 beat/cycle, 32 cycles per polynomial. Output is 256 cycles per polynomial at full out_ready. Sustained input above 1 polynomial per 256 cycles drops polynomials; this is reported by overflow and is never silent.
- The overflow decision is made only at beat 0. A polynomial is either stored whole or dropped whole.

## Structure
- Shared package ntt_pkg holds:
  - constants LANES, W, N, Q, and BEATS=N/LANES;
  - index widths $clog2(N) and $clog2(BEATS);
  - enums for bank state, write FSM and read FSM.
- Sub-module ntt_poly_bank holds the storage for one bank. It has an 8-lane write port (beat address, LANES x W data) and a 1-lane asynchronous read port (coefficient index). It is instantiated twice. The FSMs, flags and output mux live in the top module.

## Test plan
- Reset then one polynomial with coefficient i = index i, out_ready=1 -> out_valid rises 2 cycles after the last beat; 256 outputs with coeff_out==out_idx; out_last only at 255; overflow=0, range_err=0.
- Same polynomial with out_ready toggling 1/0 on alternate cycles -> coeff_out and out_idx hold while out_ready=0; all 256 values in order; no duplicates or gaps.
- Three polynomials (values p*1000+i mod 3329) sent back-to-back with out_ready=0 -> polynomials 0 and 1 stored, polynomial 2 dropped, overflow=1. Then raise out_ready -> streams polynomial 0 then 1 intact.
- Polynomial 1's beat 0 arrives in the same cycle as the final handshake (idx 255) of the bank it targets -> the beat is accepted, overflow stays 0, and polynomial 1 streams correctly.
- Beat 5 lane 3 = 3329, other coefficients < Q -> range_err=1 and output idx 43 = 3329. Then clr_err pulse -> range_err=0. clr_err in the same cycle as a new out-of-range beat -> range_err stays 1.
- r asserted at beat 17 of a fill and again during a drain at idx 100 -> all outputs 0 immediately. A fresh polynomial after release streams correctly from idx 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, index widths, state enums and small helpers for the
// NTT result collector slice.
package ntt_pkg;

   localparam int LANES  = 8;
   localparam int W      = 12;
   localparam int N      = 256;
   localparam int Q      = 3329;
   localparam int BEATS  = N / LANES;
   localparam int IDX_W  = $clog2(N);
   localparam int BEAT_W = $clog2(BEATS);
   localparam int LANE_W = $clog2(LANES);

   typedef logic [W-1:0] coeff_t;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_st_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_FILL = 2'd1,
      WR_DROP = 2'd2
   } wr_st_e;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_st_e;

   // A coefficient is out of range when it is not a canonical residue mod Q.
   function automatic logic coeff_out_of_range(input coeff_t c);
      return (c >= coeff_t'(Q));
   endfunction

endpackage

// File: rtl/ntt_result_collector_if.sv
// Beat input and coefficient stream output of the result collector.
// master = producer/consumer side (bench or neighbours), slave = collector.
interface ntt_result_collector_if;
   import ntt_pkg::*;

   logic             valid_in;
   coeff_t           coeffs_in [LANES-1:0];
   logic             out_valid;
   logic             out_ready;
   coeff_t           coeff_out;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      output valid_in, coeffs_in, out_ready,
      input  out_valid, coeff_out, out_idx, out_last
   );

   modport slave (
      input  valid_in, coeffs_in, out_ready,
      output out_valid, coeff_out, out_idx, out_last
   );

endinterface

// File: rtl/ntt_poly_bank.sv
// Storage for one polynomial: a full-beat write port and a single-coefficient
// asynchronous read port. Contents are deliberately not reset.
module ntt_poly_bank
   import ntt_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [BEAT_W-1:0] wr_beat,
   input  coeff_t            wr_data [LANES-1:0],
   input  logic [IDX_W-1:0]  rd_idx,
   output coeff_t            rd_data
);

   logic [LANES*W-1:0] mem_r [BEATS-1:0];
   logic [LANES*W-1:0] wr_row_s;
   logic [LANES*W-1:0] rd_row_s;

   // Pack the lanes of the incoming beat into one memory row, lane 0 lowest.
   always_comb begin
      wr_row_s = '0;
      for (int k = 0; k < LANES; k++) begin
         wr_row_s[k*W +: W] = wr_data[k];
      end
   end

   // Store a whole beat per write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_beat] <= wr_row_s;
      end
   end

   // Upper index bits pick the beat row, lower bits pick the lane.
   always_comb begin
      rd_row_s = mem_r[rd_idx[IDX_W-1 -: BEAT_W]];
      rd_data  = rd_row_s[rd_idx[LANE_W-1:0]*W +: W];
   end

endmodule

// File: rtl/ntt_result_collector.sv
// Collects 8-lane coefficient beats into ping-pong polynomial banks and
// streams each complete polynomial out one coefficient per handshake.
module ntt_result_collector
   import ntt_pkg::*;
(
   input  logic                   clk,
   input  logic                   r,
   ntt_result_collector_if.slave  bus,
   input  logic                   clr_err,
   output logic                   overflow,
   output logic                   range_err
);

   wr_st_e             wr_state_r;
   logic [BEAT_W-1:0]  wr_beat_r;
   logic               wr_bank_r;
   rd_st_e             rd_state_r;
   logic [IDX_W-1:0]   rd_idx_r;
   logic               rd_bank_r;
   bank_st_e           bank_st_r [2];

   logic               out_valid_r;
   coeff_t             coeff_out_r;
   logic [IDX_W-1:0]   out_idx_r;
   logic               out_last_r;
   logic               overflow_r;
   logic               range_err_r;

   logic               hs_s;
   logic               rd_start_s;
   logic               rd_last_s;
   logic               wr_bank_ok_s;
   logic               wr_start_s;
   logic               drop_start_s;
   logic               wr_en_s;
   logic               wr_done_s;
   logic               beat_bad_s;
   logic [BEAT_W-1:0]  wr_addr_s;
   logic [IDX_W-1:0]   rd_addr_s;
   coeff_t             rd_data_s;
   coeff_t             rd_data_bank_s [2];
   logic               we_bank_s [2];

   assign bus.out_valid = out_valid_r;
   assign bus.coeff_out = coeff_out_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_last  = out_last_r;
   assign overflow      = overflow_r;
   assign range_err     = range_err_r;

   // Handshake, bank-state events and storage addressing shared by both FSMs.
   always_comb begin
      hs_s         = out_valid_r & bus.out_ready;
      rd_start_s   = (rd_state_r == RD_IDLE) && (bank_st_r[rd_bank_r] == BANK_FULL);
      rd_last_s    = (rd_state_r == RD_STREAM) && hs_s && (rd_idx_r == IDX_W'(N - 1));
      // A draining bank that hands out its last coefficient this cycle is free now.
      wr_bank_ok_s = (bank_st_r[wr_bank_r] == BANK_EMPTY) ||
                     ((bank_st_r[wr_bank_r] == BANK_DRAINING) && rd_last_s &&
                      (rd_bank_r == wr_bank_r));
      wr_start_s   = (wr_state_r == WR_IDLE) && bus.valid_in && wr_bank_ok_s;
      drop_start_s = (wr_state_r == WR_IDLE) && bus.valid_in && !wr_bank_ok_s;
      wr_en_s      = wr_start_s || ((wr_state_r == WR_FILL) && bus.valid_in);
      wr_done_s    = (wr_state_r == WR_FILL) && bus.valid_in &&
                     (wr_beat_r == BEAT_W'(BEATS - 1));
      if (wr_state_r == WR_FILL) begin
         wr_addr_s = wr_beat_r;
      end else begin
         wr_addr_s = '0;
      end
      // Read one ahead so the registered output is ready for the next handshake.
      if (rd_state_r == RD_IDLE) begin
         rd_addr_s = '0;
      end else begin
         rd_addr_s = rd_idx_r + IDX_W'(1);
      end
      if (rd_bank_r) begin
         rd_data_s = rd_data_bank_s[1];
      end else begin
         rd_data_s = rd_data_bank_s[0];
      end
      we_bank_s[0] = wr_en_s && (wr_bank_r == 1'b0);
      we_bank_s[1] = wr_en_s && (wr_bank_r == 1'b1);
      beat_bad_s   = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         beat_bad_s = beat_bad_s | coeff_out_of_range(bus.coeffs_in[k]);
      end
   end

   ntt_poly_bank u_bank0 (
      .clk     (clk),
      .we      (we_bank_s[0]),
      .wr_beat (wr_addr_s),
      .wr_data (bus.coeffs_in),
      .rd_idx  (rd_addr_s),
      .rd_data (rd_data_bank_s[0])
   );

   ntt_poly_bank u_bank1 (
      .clk     (clk),
      .we      (we_bank_s[1]),
      .wr_beat (wr_addr_s),
      .wr_data (bus.coeffs_in),
      .rd_idx  (rd_addr_s),
      .rd_data (rd_data_bank_s[1])
   );

   // Per-bank lifecycle; a fill claiming a bank overrides its drain completing.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         for (int b = 0; b < 2; b++) begin
            bank_st_r[b] <= BANK_EMPTY;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_done_s && (wr_bank_r == 1'(b))) begin
               bank_st_r[b] <= BANK_FULL;
            end else if (wr_start_s && (wr_bank_r == 1'(b))) begin
               bank_st_r[b] <= BANK_FILLING;
            end else if (rd_last_s && (rd_bank_r == 1'(b))) begin
               bank_st_r[b] <= BANK_EMPTY;
            end else if (rd_start_s && (rd_bank_r == 1'(b))) begin
               bank_st_r[b] <= BANK_DRAINING;
            end else begin
               bank_st_r[b] <= bank_st_r[b];
            end
         end
      end
   end

   // Write FSM: accept or drop a whole polynomial, decided at its first beat.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         wr_state_r <= WR_IDLE;
         wr_beat_r  <= '0;
         wr_bank_r  <= 1'b0;
      end else begin
         case (wr_state_r)
            WR_IDLE: begin
               if (bus.valid_in) begin
                  wr_beat_r <= BEAT_W'(1);
                  if (wr_bank_ok_s) begin
                     wr_state_r <= WR_FILL;
                  end else begin
                     wr_state_r <= WR_DROP;
                  end
               end
            end
            WR_FILL: begin
               if (bus.valid_in) begin
                  if (wr_beat_r == BEAT_W'(BEATS - 1)) begin
                     wr_state_r <= WR_IDLE;
                     wr_beat_r  <= '0;
                     wr_bank_r  <= ~wr_bank_r;
                  end else begin
                     wr_beat_r <= wr_beat_r + BEAT_W'(1);
                  end
               end
            end
            WR_DROP: begin
               if (bus.valid_in) begin
                  if (wr_beat_r == BEAT_W'(BEATS - 1)) begin
                     wr_state_r <= WR_IDLE;
                     wr_beat_r  <= '0;
                  end else begin
                     wr_beat_r <= wr_beat_r + BEAT_W'(1);
                  end
               end
            end
            default: begin
               wr_state_r <= WR_IDLE;
               wr_beat_r  <= '0;
            end
         endcase
      end
   end

   // Read FSM with registered stream outputs; outputs hold while stalled.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         rd_state_r  <= RD_IDLE;
         rd_idx_r    <= '0;
         rd_bank_r   <= 1'b0;
         out_valid_r <= 1'b0;
         coeff_out_r <= '0;
         out_idx_r   <= '0;
         out_last_r  <= 1'b0;
      end else begin
         case (rd_state_r)
            RD_IDLE: begin
               if (rd_start_s) begin
                  rd_state_r  <= RD_STREAM;
                  rd_idx_r    <= '0;
                  out_valid_r <= 1'b1;
                  coeff_out_r <= rd_data_s;
                  out_idx_r   <= '0;
                  out_last_r  <= 1'b0;
               end
            end
            RD_STREAM: begin
               if (hs_s) begin
                  if (rd_idx_r == IDX_W'(N - 1)) begin
                     rd_state_r  <= RD_IDLE;
                     rd_idx_r    <= '0;
                     rd_bank_r   <= ~rd_bank_r;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     rd_idx_r    <= rd_idx_r + IDX_W'(1);
                     out_idx_r   <= rd_idx_r + IDX_W'(1);
                     coeff_out_r <= rd_data_s;
                     out_last_r  <= (rd_idx_r == IDX_W'(N - 2));
                  end
               end
            end
            default: begin
               rd_state_r  <= RD_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags; a set event in the same cycle beats the clear.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         overflow_r  <= 1'b0;
         range_err_r <= 1'b0;
      end else begin
         if (drop_start_s) begin
            overflow_r <= 1'b1;
         end else if (clr_err) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         if (wr_en_s && beat_bad_s) begin
            range_err_r <= 1'b1;
         end else if (clr_err) begin
            range_err_r <= 1'b0;
         end else begin
            range_err_r <= range_err_r;
         end
      end
   end

endmodule

// File: tb/tb_ntt_result_collector.sv
// Self-checking bench for ntt_result_collector: expected coefficients are
// queued when beats are driven and compared as the DUT hands them out.
module tb_ntt_result_collector;
   import ntt_pkg::*;

   logic clk = 1'b0;
   logic r = 1'b0;
   logic clr_err = 1'b0;
   logic overflow;
   logic range_err;

   int checks = 0;
   int errors = 0;

   int exp_data[$];
   int exp_idx[$];

   logic             hold_pend = 1'b0;
   logic [W-1:0]     prev_data = '0;
   logic [IDX_W-1:0] prev_idx = '0;

   ntt_result_collector_if bus();

   ntt_result_collector dut (
      .clk       (clk),
      .r         (r),
      .bus       (bus.slave),
      .clr_err   (clr_err),
      .overflow  (overflow),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   function automatic int golden(input int p, input int i);
      return (p * 1000 + i) % 3329;
   endfunction

   // Scoreboard monitor: sample away from the rising edge.
   always @(negedge clk) begin
      int ed;
      int ei;
      if (!r) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.coeff_out !== prev_data || bus.out_idx !== prev_idx) begin
               errors++;
               $display("FAIL hold: got valid=%0b data=%0d idx=%0d, expected valid=1 data=%0d idx=%0d",
                        bus.out_valid, bus.coeff_out, bus.out_idx, prev_data, prev_idx);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got data=%0d idx=%0d, expected no output",
                        bus.coeff_out, bus.out_idx);
            end else begin
               ed = exp_data.pop_front();
               ei = exp_idx.pop_front();
               if (bus.coeff_out !== 12'(ed) || bus.out_idx !== 8'(ei) ||
                   bus.out_last !== (ei == 255)) begin
                  errors++;
                  $display("FAIL stream: got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d last=%0b",
                           bus.coeff_out, bus.out_idx, bus.out_last, ed, ei, (ei == 255));
               end
            end
            hold_pend = 1'b0;
         end else begin
            hold_pend = (bus.out_valid === 1'b1);
         end
         prev_data = bus.coeff_out;
         prev_idx  = bus.out_idx;
      end
   end

   // Drive nbeats beats of polynomial p (starting at posedge+1); optionally
   // replace one coefficient, pulse clr_err with beat 0, and queue the result.
   task automatic send_poly(input int p, input int bad_idx, input int bad_val,
                            input bit store, input int nbeats, input bit clr_at0);
      int v;
      int i;
      for (int b = 0; b < nbeats; b++) begin
         bus.valid_in = 1'b1;
         clr_err = (b == 0) ? clr_at0 : 1'b0;
         for (int k = 0; k < LANES; k++) begin
            i = b * LANES + k;
            v = (i == bad_idx) ? bad_val : golden(p, i);
            bus.coeffs_in[k] = 12'(v);
            if (store) begin
               exp_data.push_back(v);
               exp_idx.push_back(i);
            end
         end
         @(posedge clk); #1;
      end
      bus.valid_in = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output int left);
      for (int c = 0; c < budget && exp_data.size() != 0; c++) begin
         @(posedge clk); #1;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      left = exp_data.size();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 r = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
      checks++; if (bus.coeff_out !== 12'd0) begin errors++; $display("FAIL reset_coeff: got %0d expected 0", bus.coeff_out); end
      checks++; if (bus.out_idx !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", bus.out_idx); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", bus.out_last); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %0b expected 0", range_err); end
   endtask

   task automatic test_basic();
      int left;
      bus.out_ready = 1'b1;
      send_poly(0, -1, 0, 1'b1, BEATS, 1'b0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%0b expected 0", bus.out_valid); end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 8'd0) begin
         errors++; $display("FAIL latency_first: got valid=%0b idx=%0d expected valid=1 idx=0", bus.out_valid, bus.out_idx);
      end
      wait_drain(600, left);
      checks++; if (left != 0) begin errors++; $display("FAIL basic_drain: got %0d left expected 0", left); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %0b expected 0", overflow); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL basic_range_err: got %0b expected 0", range_err); end
   endtask

   task automatic test_toggle_ready();
      int left;
      bus.out_ready = 1'b0;
      send_poly(1, -1, 0, 1'b1, BEATS, 1'b0);
      for (int c = 0; c < 1500 && exp_data.size() != 0; c++) begin
         @(posedge clk); #1;
         bus.out_ready = ~bus.out_ready;
      end
      bus.out_ready = 1'b1;
      wait_drain(10, left);
      checks++; if (left != 0) begin errors++; $display("FAIL toggle_drain: got %0d left expected 0", left); end
   endtask

   task automatic test_overflow();
      int left;
      bus.out_ready = 1'b0;
      send_poly(2, -1, 0, 1'b1, BEATS, 1'b0);
      send_poly(3, -1, 0, 1'b1, BEATS, 1'b0);
      send_poly(4, -1, 0, 1'b0, BEATS, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", overflow); end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 8'd0 || bus.coeff_out !== 12'(golden(2, 0))) begin
         errors++; $display("FAIL overflow_stall: got valid=%0b idx=%0d data=%0d expected valid=1 idx=0 data=%0d",
                            bus.out_valid, bus.out_idx, bus.coeff_out, golden(2, 0));
      end
      bus.out_ready = 1'b1;
      wait_drain(1200, left);
      checks++; if (left != 0) begin errors++; $display("FAIL overflow_drain: got %0d left expected 0", left); end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %0b expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      int left;
      bit found;
      bus.out_ready = 1'b0;
      send_poly(5, -1, 0, 1'b1, BEATS, 1'b0);
      send_poly(6, -1, 0, 1'b1, BEATS, 1'b0);
      bus.out_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 600 && !found; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && bus.out_idx === 8'd255) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL b2b_find_last: got none expected idx 255"); end
      send_poly(7, -1, 0, 1'b1, BEATS, 1'b0);
      wait_drain(1200, left);
      checks++; if (left != 0) begin errors++; $display("FAIL b2b_drain: got %0d left expected 0", left); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %0b expected 0", overflow); end
   endtask

   task automatic test_range();
      int left;
      bus.out_ready = 1'b1;
      send_poly(8, 43, 3329, 1'b1, BEATS, 1'b0);
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set: got %0b expected 1", range_err); end
      wait_drain(600, left);
      checks++; if (left != 0) begin errors++; $display("FAIL range_drain: got %0d left expected 0", left); end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_clear: got %0b expected 0", range_err); end
      send_poly(9, 2, 4000, 1'b1, BEATS, 1'b1);
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set_wins: got %0b expected 1", range_err); end
      wait_drain(600, left);
      checks++; if (left != 0) begin errors++; $display("FAIL range_drain2: got %0d left expected 0", left); end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   task automatic test_reset_mid();
      int left;
      bit found;
      bus.out_ready = 1'b1;
      send_poly(10, -1, 0, 1'b0, 17, 1'b0);
      bus.valid_in = 1'b1;
      #2 r = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.coeff_out !== 12'd0 || bus.out_idx !== 8'd0 ||
          bus.out_last !== 1'b0 || overflow !== 1'b0 || range_err !== 1'b0) begin
         errors++; $display("FAIL reset_fill: got valid=%0b data=%0d idx=%0d last=%0b ovf=%0b rerr=%0b expected all 0",
                            bus.out_valid, bus.coeff_out, bus.out_idx, bus.out_last, overflow, range_err);
      end
      bus.valid_in = 1'b0;
      @(posedge clk); #1 r = 1'b1;
      send_poly(11, -1, 0, 1'b1, BEATS, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && bus.out_idx === 8'd100) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL reset_find_100: got none expected idx 100"); end
      #2 r = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.coeff_out !== 12'd0 || bus.out_idx !== 8'd0 || bus.out_last !== 1'b0) begin
         errors++; $display("FAIL reset_drain: got valid=%0b data=%0d idx=%0d last=%0b expected all 0",
                            bus.out_valid, bus.coeff_out, bus.out_idx, bus.out_last);
      end
      exp_data.delete();
      exp_idx.delete();
      @(posedge clk); #1 r = 1'b1;
      send_poly(12, -1, 0, 1'b1, BEATS, 1'b0);
      wait_drain(600, left);
      checks++; if (left != 0) begin errors++; $display("FAIL reset_fresh_drain: got %0d left expected 0", left); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_fresh_overflow: got %0b expected 0", overflow); end
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.out_ready = 1'b0;
      for (int k = 0; k < LANES; k++) bus.coeffs_in[k] = '0;
      test_reset();
      test_basic();
      test_toggle_ready();
      test_overflow();
      test_back_to_back();
      test_range();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no completion expected finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule
